// File: rtl/ls_mem_queue_pkg.sv
// Shared types and constants for the load/store memory queue.
// Holds the byte/word/address types, the read/write opcode encoding, the
// packed queue entry layout, the FSM state encoding and a helper that turns a
// requested byte count into the number of bus beats actually performed.
package ls_mem_queue_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;
    typedef logic [7:0]  byte_t;

    localparam logic READ_SIGNAL  = 1'b0;
    localparam logic WRITE_SIGNAL = 1'b1;

    // Queue entry: opcode, start address, beat count (1, 2 or 4), store data.
    typedef struct packed {
        logic       oper;
        addr_t      addr;
        logic [2:0] nbytes;
        word_t      data;
    } ls_req_t;

    localparam int LS_REQ_W = 1 + 32 + 3 + 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } ls_state_e;

    // Any size other than 1 or 2 is a full word.
    function automatic logic [2:0] size_to_n(input logic [7:0] size);
        case (size)
            8'd1:    return 3'd1;
            8'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/ls_mem_queue_fifo.sv
// ls_req_fifo: in-order storage for pending load/store requests.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   push/push_req write push_req at the tail (ignored when full)
//   pop           advance the head (ignored when empty)
//   head          entry at the head pointer
//   count         number of stored entries
// Full/empty come from count, so head==tail is never used to decide either.
module ls_req_fifo
    import ls_mem_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  ls_req_t        push_req,
    input  logic           pop,
    output ls_req_t        head,
    output logic [PTR_W:0] count
);

    ls_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    always_comb begin
        do_push = push && (count_q < (PTR_W + 1)'(DEPTH));
        do_pop  = pop && (count_q != '0);
        head_d  = do_pop  ? ptr_inc(head_q) : head_q;
        tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= push_req;
        end
    end

    assign head  = mem_q[head_q];
    assign count = count_q;

endmodule

// File: rtl/ls_mem_queue.sv
// ls_mem_queue: memory-side responder for load/store execute requests.
// Requests are queued in order and serialised onto a byte-wide RAM bus.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   rdy          global ready; low freezes all state and masks mem_wr/finish
//   en_ls        push request (ls_oper, ls_addr, ls_size, ls_data)
//   qsize        accepted but not retired entries, including the active one
//   finish       one-cycle pulse when a read retires; ls_data_out valid
//   ls_data_out  read bytes in address order, last byte in [7:0]
//   mem_din      RAM read byte, valid the cycle after mem_a
//   mem_dout     RAM write byte
//   mem_a        RAM byte address
//   mem_wr       RAM write strobe
module ls_mem_queue
    import ls_mem_queue_pkg::*;
#(
    parameter int QUEEN_SIZE = 16,
    parameter int PTR_W      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        en_ls,
    input  logic        ls_oper,
    input  logic [31:0] ls_addr,
    input  logic [7:0]  ls_size,
    input  logic [31:0] ls_data,
    output logic [31:0] qsize,
    output logic        finish,
    output logic [31:0] ls_data_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    ls_state_e      state_q, state_d;
    logic [2:0]     k_q, k_d;
    logic [2:0]     n_q, n_d;
    addr_t          addr_q, addr_d;
    word_t          data_q, data_d;
    word_t          sh_q, sh_d;
    word_t          ls_data_out_q, ls_data_out_d;
    logic           finish_q, finish_d;

    ls_req_t        push_req, head;
    logic [PTR_W:0] fifo_count;
    logic           push, pop, busy, issuing;
    word_t          wr_shift;

    assign push_req = '{oper: ls_oper, addr: ls_addr, nbytes: size_to_n(ls_size), data: ls_data};

    ls_req_fifo #(
        .DEPTH (QUEEN_SIZE),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

    // The active entry has already left the fifo but still counts as queued.
    assign busy  = (state_q != ST_IDLE);
    assign qsize = 32'(fifo_count) + 32'(busy);
    assign push  = rdy && en_ls && (qsize < 32'(QUEEN_SIZE));

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        n_d           = n_q;
        addr_d        = addr_q;
        data_d        = data_q;
        sh_d          = sh_q;
        ls_data_out_d = ls_data_out_q;
        finish_d      = finish_q;
        pop           = 1'b0;
        if (rdy) begin
            finish_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_count != '0) begin
                        pop     = 1'b1;
                        addr_d  = head.addr;
                        data_d  = head.data;
                        n_d     = head.nbytes;
                        k_d     = 3'd0;
                        sh_d    = '0;
                        state_d = (head.oper == WRITE_SIGNAL) ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if (k_q == 3'(n_q - 3'd1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d = 3'(k_q + 3'd1);
                    end
                end
                ST_RD: begin
                    // Beat k issues address k and captures the byte addressed
                    // by beat k-1; one extra beat (k==n) collects the last byte.
                    if (k_q != 3'd0) begin
                        sh_d = {sh_q[23:0], mem_din};
                    end
                    if (k_q == n_q) begin
                        ls_data_out_d = {sh_q[23:0], mem_din};
                        finish_d      = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        k_d = 3'(k_q + 3'd1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            k_q           <= '0;
            n_q           <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            sh_q          <= '0;
            ls_data_out_q <= '0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            n_q           <= n_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            sh_q          <= sh_d;
            ls_data_out_q <= ls_data_out_d;
            finish_q      <= finish_d;
        end
    end

    // RAM drive decoded from registered state; the bus idles at zero.
    assign issuing  = (state_q == ST_WR) || ((state_q == ST_RD) && (k_q < n_q));
    assign wr_shift = data_q >> {k_q[1:0], 3'b000};
    assign mem_a    = issuing ? (addr_q + 32'(k_q)) : '0;
    assign mem_dout = (state_q == ST_WR) ? wr_shift[7:0] : '0;
    assign mem_wr   = rdy && (state_q == ST_WR);
    assign finish   = rdy && finish_q;
    assign ls_data_out = ls_data_out_q;

endmodule
